// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: in-order elastic pipeline register chain.
//   Stage 0 is youngest, stage NUM_STAGES-1 is oldest and drives the retire port.
//   Each stage carries a valid bit and a WIDTH-bit payload. Per-stage hold and the
//   downstream ready chain provide backpressure. A targeted flush kills the stages
//   younger than flush_idx. Three saturating performance counters are included.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   in_valid/in_data  producer entry into stage 0; in_ready is stage-0 acceptance
//   hold              per-stage advance inhibit
//   flush/flush_idx   kill stages 0..flush_idx-1 (and any load into flush_idx)
//   out_valid/out_data/out_ready   retire handshake on the oldest stage
//   stage_valid/stage_data         per-stage visibility (stage k at [k*WIDTH +: WIDTH])
//   cnt_retired/cnt_stall/cnt_killed   saturating event counters
module pipe_stage_chain #(
    parameter int unsigned NUM_STAGES = 5,
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    input  logic [WIDTH-1:0]                  in_data,
    output logic                              in_ready,
    input  logic [NUM_STAGES-1:0]             hold,
    input  logic                              flush,
    input  logic [$clog2(NUM_STAGES+1)-1:0]   flush_idx,
    output logic                              out_valid,
    output logic [WIDTH-1:0]                  out_data,
    input  logic                              out_ready,
    output logic [NUM_STAGES-1:0]             stage_valid,
    output logic [NUM_STAGES*WIDTH-1:0]       stage_data,
    output logic [CNT_W-1:0]                  cnt_retired,
    output logic [CNT_W-1:0]                  cnt_stall,
    output logic [CNT_W-1:0]                  cnt_killed
);

    localparam int unsigned IDX_W = $clog2(NUM_STAGES + 1);
    // Enough bits for up to NUM_STAGES killed stages plus the dropped input.
    localparam int unsigned KW    = $clog2(NUM_STAGES + 2);

    logic [NUM_STAGES-1:0]             valid_q, valid_d;
    logic [NUM_STAGES-1:0][WIDTH-1:0]  data_q, data_d;
    logic [CNT_W-1:0]                  retired_q, retired_d;
    logic [CNT_W-1:0]                  stall_q, stall_d;
    logic [CNT_W-1:0]                  killed_q, killed_d;

    logic [NUM_STAGES-1:0]             adv;
    logic                              rdy0;
    logic                              accept;
    logic                              kill_any;
    logic [NUM_STAGES-1:0]             load;
    logic [NUM_STAGES-1:0][WIDTH-1:0]  src;
    logic [KW-1:0]                     killed_n;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [KW-1:0]    b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + (CNT_W+1)'(b);
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    // Ready chain, evaluated oldest to youngest; r carries rdy[k+1] down the chain.
    always_comb begin
        logic r;
        adv = '0;
        r   = out_ready;
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            adv[k] = valid_q[k] && !hold[k] && r;
            r      = !valid_q[k] || adv[k];
        end
        rdy0 = r;
    end

    assign in_ready = rdy0 && !hold[0];
    assign accept   = in_valid && in_ready;
    assign kill_any = flush && (flush_idx != '0);

    // Each stage's load source: stage 0 from the input port, others from the stage below.
    assign load = {adv[NUM_STAGES-2:0], accept};
    assign src  = {data_q[NUM_STAGES-2:0], in_data};

    // Next-state for stages and counters.
    always_comb begin
        logic in_zone;
        logic load_ok;
        valid_d  = valid_q;
        data_d   = data_q;
        killed_n = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            in_zone = kill_any && (IDX_W'(k) < flush_idx);
            // Loads into stages 0..flush_idx are dropped, including the hop into flush_idx.
            load_ok = load[k] && !(kill_any && (IDX_W'(k) <= flush_idx));
            if (in_zone) begin
                valid_d[k] = 1'b0;
            end else if (load_ok) begin
                valid_d[k] = 1'b1;
            end else if (adv[k]) begin
                valid_d[k] = 1'b0;
            end
            // Payload only changes on a real load, so idle stages stay quiet.
            if (load_ok) begin
                data_d[k] = src[k];
            end
            if (in_zone && valid_q[k]) begin
                killed_n = killed_n + KW'(1);
            end
        end
        // With a full flush the oldest entry still retires if it handshakes.
        if (kill_any && (flush_idx == IDX_W'(NUM_STAGES)) && adv[NUM_STAGES-1]) begin
            killed_n = killed_n - KW'(1);
        end
        if (kill_any && accept) begin
            killed_n = killed_n + KW'(1);
        end
        retired_d = sat_add(retired_q, KW'(valid_q[NUM_STAGES-1] && out_ready));
        stall_d   = sat_add(stall_q, KW'(in_valid && !in_ready));
        killed_d  = sat_add(killed_q, killed_n);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q   <= '0;
            data_q    <= '0;
            retired_q <= '0;
            stall_q   <= '0;
            killed_q  <= '0;
        end else begin
            valid_q   <= valid_d;
            data_q    <= data_d;
            retired_q <= retired_d;
            stall_q   <= stall_d;
            killed_q  <= killed_d;
        end
    end

    assign out_valid   = valid_q[NUM_STAGES-1];
    assign out_data    = data_q[NUM_STAGES-1];
    assign stage_valid = valid_q;
    assign stage_data  = data_q;
    assign cnt_retired = retired_q;
    assign cnt_stall   = stall_q;
    assign cnt_killed  = killed_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Testbench for pipe_stage_chain: two instances (32-bit and 4-bit counters) share
// stimulus; a slot-level model of the pipeline predicts every observable.
module tb_pipe_stage_chain;

    localparam int N = 5;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           in_valid = 1'b0;
    logic [W-1:0]   in_data = '0;
    logic [N-1:0]   hold = '0;
    logic           flush = 1'b0;
    logic [2:0]     flush_idx = '0;
    logic           out_ready = 1'b0;

    logic           a_in_ready, a_out_valid;
    logic [W-1:0]   a_out_data;
    logic [N-1:0]   a_stage_valid;
    logic [N*W-1:0] a_stage_data;
    logic [31:0]    a_cnt_retired, a_cnt_stall, a_cnt_killed;

    logic           b_in_ready, b_out_valid;
    logic [W-1:0]   b_out_data;
    logic [N-1:0]   b_stage_valid;
    logic [N*W-1:0] b_stage_data;
    logic [3:0]     b_cnt_retired, b_cnt_stall, b_cnt_killed;

    pipe_stage_chain #(.NUM_STAGES(N), .WIDTH(W), .CNT_W(32)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(a_in_ready),
        .hold(hold), .flush(flush), .flush_idx(flush_idx), .out_valid(a_out_valid),
        .out_data(a_out_data), .out_ready(out_ready), .stage_valid(a_stage_valid),
        .stage_data(a_stage_data), .cnt_retired(a_cnt_retired), .cnt_stall(a_cnt_stall),
        .cnt_killed(a_cnt_killed)
    );

    pipe_stage_chain #(.NUM_STAGES(N), .WIDTH(W), .CNT_W(4)) u_dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(b_in_ready),
        .hold(hold), .flush(flush), .flush_idx(flush_idx), .out_valid(b_out_valid),
        .out_data(b_out_data), .out_ready(out_ready), .stage_valid(b_stage_valid),
        .stage_data(b_stage_data), .cnt_retired(b_cnt_retired), .cnt_stall(b_cnt_stall),
        .cnt_killed(b_cnt_killed)
    );

    always #5 clk = ~clk;

    // Model: slot occupancy and payloads, plus event totals.
    bit          mv[N];
    logic [31:0] md[N];
    longint      c_ret, c_stall, c_kill;
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] sat4(input longint v);
        return (v > 15) ? 4'hF : 4'(v);
    endfunction

    task automatic model_clear();
        for (int k = 0; k < N; k++) begin
            mv[k] = 1'b0;
            md[k] = '0;
        end
        c_ret = 0; c_stall = 0; c_kill = 0;
    endtask

    task automatic check_state();
        logic [N-1:0] ev;
        for (int k = 0; k < N; k++) ev[k] = mv[k];
        check("stage_valid", 64'(a_stage_valid), 64'(ev));
        check("stage_valid_sat", 64'(b_stage_valid), 64'(ev));
        check("out_valid", 64'(a_out_valid), 64'(mv[N-1]));
        if (mv[N-1]) check("out_data", 64'(a_out_data), 64'(md[N-1]));
        for (int k = 0; k < N; k++) begin
            if (mv[k]) begin
                check("stage_data", 64'(a_stage_data[k*W +: W]), 64'(md[k]));
                check("stage_data_sat", 64'(b_stage_data[k*W +: W]), 64'(md[k]));
            end
        end
        check("cnt_retired", 64'(a_cnt_retired), 64'(c_ret[31:0]));
        check("cnt_stall", 64'(a_cnt_stall), 64'(c_stall[31:0]));
        check("cnt_killed", 64'(a_cnt_killed), 64'(c_kill[31:0]));
        check("cnt_retired_sat", 64'(b_cnt_retired), 64'(sat4(c_ret)));
        check("cnt_stall_sat", 64'(b_cnt_stall), 64'(sat4(c_stall)));
        check("cnt_killed_sat", 64'(b_cnt_killed), 64'(sat4(c_kill)));
    endtask

    // One clock: check state, drive inputs, predict, then commit the model at the edge.
    task automatic step(input bit iv, input logic [31:0] id, input logic [N-1:0] hd,
                        input bit ordy, input bit fl, input int fi);
        bit          occ[N];
        int          np[N];
        bit          nv[N];
        logic [31:0] nd[N];
        bit          exp_rdy, acc, kz;
        @(negedge clk);
        check_state();
        in_valid  = iv;
        in_data   = id;
        hold      = hd;
        out_ready = ordy;
        flush     = fl;
        flush_idx = 3'(fi);
        #1;
        // Walk from the oldest slot; an entry moves if its hold is clear and the slot ahead is free.
        for (int k = 0; k < N; k++) begin
            occ[k] = mv[k];
            np[k]  = k;
            nv[k]  = 1'b0;
            nd[k]  = md[k];
        end
        for (int k = N - 1; k >= 0; k--) begin
            if (mv[k] && !hd[k]) begin
                if (k == N - 1) begin
                    if (ordy) begin
                        np[k]  = -1;
                        occ[k] = 1'b0;
                    end
                end else if (!occ[k+1]) begin
                    np[k]    = k + 1;
                    occ[k+1] = 1'b1;
                    occ[k]   = 1'b0;
                end
            end
        end
        exp_rdy = !occ[0] && !hd[0];
        acc     = iv && exp_rdy;
        kz      = fl && (fi > 0);
        check("in_ready", 64'(a_in_ready), 64'(exp_rdy));
        check("in_ready_sat", 64'(b_in_ready), 64'(exp_rdy));
        if (mv[N-1] && ordy) c_ret++;
        if (iv && !exp_rdy) c_stall++;
        for (int k = 0; k < N; k++) begin
            if (mv[k] && np[k] >= 0) begin
                if (kz && k < fi) begin
                    c_kill++;
                end else begin
                    nv[np[k]] = 1'b1;
                    nd[np[k]] = md[k];
                end
            end
        end
        if (acc) begin
            if (kz) begin
                c_kill++;
            end else begin
                nv[0] = 1'b1;
                nd[0] = id;
            end
        end
        @(posedge clk);
        for (int k = 0; k < N; k++) begin
            mv[k] = nv[k];
            md[k] = nd[k];
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, '0, 1'b1, 1'b0, 0);
    endtask

    // Reset asserted between edges; everything must clear without a clock.
    task automatic async_reset();
        #2;
        in_valid = 1'b0;
        flush    = 1'b0;
        hold     = '0;
        rst      = 1'b0;
        #1;
        check("rst_stage_valid", 64'(a_stage_valid), 64'h0);
        check("rst_out_valid", 64'(a_out_valid), 64'h0);
        check("rst_in_ready", 64'(a_in_ready), 64'h1);
        check("rst_cnt_retired", 64'(a_cnt_retired), 64'h0);
        check("rst_cnt_stall", 64'(a_cnt_stall), 64'h0);
        check("rst_cnt_killed", 64'(a_cnt_killed), 64'h0);
        check("rst_cnt_retired_sat", 64'(b_cnt_retired), 64'h0);
        for (int k = 0; k < N; k++) check("rst_stage_data", 64'(a_stage_data[k*W +: W]), 64'h0);
        model_clear();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        model_clear();
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Stream of 8 entries at full throughput.
        for (int i = 0; i < 8; i++) step(1'b1, 32'h10 + 32'(i), '0, 1'b1, 1'b0, 0);
        idle(6);
        #1;
        check("stream_retired", 64'(a_cnt_retired), 64'd8);
        check("stream_stall", 64'(a_cnt_stall), 64'd0);

        // Backpressure: fill with out_ready low, then stall for 3 cycles, then drain.
        async_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 32'h20 + 32'(i), '0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 3; i++) step(1'b1, 32'h25, '0, 1'b0, 1'b0, 0);
        #1;
        check("bp_full", 64'(a_stage_valid), 64'h1F);
        check("bp_stall", 64'(a_cnt_stall), 64'd3);
        idle(8);
        #1;
        check("bp_retired", 64'(a_cnt_retired), 64'd5);

        // Hold on stage 3 for two cycles mid-stream.
        async_reset();
        for (int i = 0; i < 10; i++)
            step(1'b1, 32'h40 + 32'(i), (i == 3 || i == 4) ? 5'b01000 : 5'b00000, 1'b1, 1'b0, 0);
        idle(8);

        // Flush at index 2 on a full chain with an input being accepted.
        async_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 32'h30 + 32'(i), '0, 1'b0, 1'b0, 0);
        step(1'b1, 32'h35, '0, 1'b1, 1'b1, 2);
        #1;
        check("flush_valid", 64'(a_stage_valid), 64'h18);
        idle(4);

        // Full flush: oldest still retires.
        for (int i = 0; i < 5; i++) step(1'b1, 32'h50 + 32'(i), '0, 1'b0, 1'b0, 0);
        step(1'b1, 32'h55, '0, 1'b1, 1'b1, N);
        idle(2);

        // Saturation of the 4-bit counters.
        async_reset();
        for (int i = 0; i < 20; i++) step(1'b1, 32'h60 + 32'(i), '0, 1'b1, 1'b0, 0);
        idle(6);
        #1;
        check("sat_retired", 64'(b_cnt_retired), 64'hF);
        check("sat_retired_wide", 64'(a_cnt_retired), 64'd20);

        // Mid-operation reset while full, then a normal entry.
        for (int i = 0; i < 5; i++) step(1'b1, 32'h70 + 32'(i), '0, 1'b0, 1'b0, 0);
        async_reset();
        step(1'b1, 32'h80, '0, 1'b1, 1'b0, 0);
        idle(5);

        // Randomized traffic; hold on the oldest stage is left clear.
        for (int i = 0; i < 600; i++) begin
            logic [N-1:0] hd;
            bit fl;
            hd = '0;
            for (int k = 0; k < N - 1; k++) hd[k] = ($urandom_range(0, 9) == 0);
            fl = ($urandom_range(0, 11) == 0);
            step($urandom_range(0, 9) < 7, $urandom, hd, $urandom_range(0, 9) < 7,
                 fl, int'($urandom_range(0, N)));
        end
        idle(8);
        @(negedge clk);
        check_state();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
